trivium_stream_ctrl: RTL
========================

TRIVIUM_STREAM_CTRL -- requirements
Module: trivium_stream_ctrl

Interface
REQ-001 Parameter WARMUP, default 1152, number of core warm-up steps after key/IV load; legal range 1..2047.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  pulse; begins a new cipher session; honoured only in IDLE.
REQ-005 stop  input  1  ends session; honoured only in FETCH.
REQ-006 core_init  output  1  one-cycle pulse to keystream core: load key/IV.
REQ-007 core_step  output  1  advance keystream core one bit this cycle.
REQ-008 core_ks  input  1  keystream bit, valid in any cycle with core_step=1.
REQ-009 fifo_condition  input  2  FIFO status: 00 empty, 10 partial, 11 full.
REQ-010 fifo_read  output  1  FIFO pop request, one-cycle pulse.
REQ-011 fifo_dout  input  8  FIFO data, valid when fifo_read_stb=1.
REQ-012 fifo_read_stb  input  1  FIFO data-valid strobe, arrives cycle after fifo_read.
REQ-013 dout  output  8  ciphertext byte.
REQ-014 dout_valid  output  1  dout holds a valid byte.
REQ-015 out_ready  input  1  downstream accepts dout when dout_valid=1 and out_ready=1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 byte_count  output  16  bytes delivered this session; wraps 0xFFFF->0x0000.

Function
REQ-018 FSM states: IDLE, INIT, WARMUP, FETCH, WAIT_DATA, GEN, OUT; state registered.
REQ-019 IDLE: start=1 -> INIT next cycle, byte_count cleared to 0; otherwise remain.
REQ-020 INIT: core_init=1 for exactly this cycle; -> WARMUP; step counter cleared.
REQ-021 WARMUP: core_step=1 every cycle; core_ks ignored; after exactly WARMUP cycles -> FETCH.
REQ-022 FETCH: stop=1 -> IDLE, no read (stop has priority); else fifo_condition!=00 -> fifo_read=1 this cycle, -> WAIT_DATA; else fifo_read=0, remain.
REQ-023 WAIT_DATA: fifo_read_stb=1 -> capture fifo_dout into data register, bit counter=0, -> GEN; else remain, no further fifo_read.
REQ-024 GEN: core_step=1 for exactly 8 consecutive cycles; core_ks of k-th cycle (k=0..7) stored as keystream bit k (LSB first).
REQ-025 On 8th GEN cycle: dout <= data ^ {core_ks, ks[6:0]}; dout_valid <= 1; -> OUT.
REQ-026 OUT: dout and dout_valid held stable until out_ready=1; on that handshake cycle byte_count increments, -> FETCH, dout_valid=0 from next cycle.
REQ-027 core_step=0 in IDLE, INIT, FETCH, WAIT_DATA, OUT (keystream never advances under backpressure).
REQ-028 fifo_read asserted only in FETCH; never more than one read outstanding.
REQ-029 Latency: fifo_read at cycle t, stb at t+1 -> dout_valid=1 at t+10.
REQ-030 start outside IDLE ignored; stop outside FETCH ignored (byte in flight always completes).
REQ-031 dout retains last value when dout_valid=0.

Reset
REQ-032 rst=1 at a clock edge: state IDLE; counters, data and keystream registers 0; dout=0, dout_valid=0, fifo_read=0, core_init=0, core_step=0, busy=0, byte_count=0.
REQ-033 rst has priority over every input in every state, including mid-WARMUP and mid-GEN; no partial byte is emitted afterwards.

Verification
REQ-034 WARMUP=4, start pulse -> core_init high 1 cycle, then core_step high exactly 4 cycles, then FSM in FETCH with busy=1.
REQ-035 FIFO holds 0xA5, core_ks sequence 1,0,1,0,1,0,1,0 -> dout=0xF0 (0xA5^0x55), dout_valid at read+10 cycles, byte_count=1.
REQ-036 fifo_condition=00 for 20 cycles in FETCH -> fifo_read stays 0, core_step stays 0; condition->10 -> fifo_read pulses next cycle.
REQ-037 out_ready=0 for 5 cycles in OUT -> dout/dout_valid stable, core_step=0, no fifo_read; out_ready=1 -> byte_count increments, FETCH.
REQ-038 stop and fifo_condition=10 in same FETCH cycle -> IDLE, no fifo_read; start in GEN -> ignored.
REQ-039 rst asserted in 3rd GEN cycle -> all outputs 0 next cycle, dout_valid never asserted, start required to resume.

Source files
------------

// File: rtl/trivium_stream_ctrl.sv
// Session controller between a bit-serial keystream core, a byte FIFO and a
// ready/valid ciphertext output: warms the core up, then XORs 8 keystream bits per byte.
module trivium_stream_ctrl #(
    parameter int WARMUP = 1152
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    output logic        core_init,
    output logic        core_step,
    input  logic        core_ks,
    input  logic [1:0]  fifo_condition,
    output logic        fifo_read,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_read_stb,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WARMUP,
        S_FETCH,
        S_WAIT_DATA,
        S_GEN,
        S_OUT
    } state_t;

    localparam logic [10:0] WARMUP_LAST = 11'(WARMUP - 1);

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_step_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_data;
    logic [6:0]  r_ks;
    logic [7:0]  r_dout;
    logic        r_dout_valid;
    logic [15:0] r_byte_count;
    logic        w_warm_done;
    logic        w_fifo_has_data;

    assign w_warm_done     = (r_step_cnt == WARMUP_LAST);
    assign w_fifo_has_data = (fifo_condition != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_INIT;
            S_INIT:      w_next = S_WARMUP;
            S_WARMUP:    if (w_warm_done) w_next = S_FETCH;
            // stop wins over a pending FIFO read so a session can end cleanly
            S_FETCH: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else if (w_fifo_has_data) begin
                    w_next = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: if (fifo_read_stb) w_next = S_GEN;
            S_GEN:       if (r_bit_cnt == 3'd7) w_next = S_OUT;
            S_OUT:       if (out_ready) w_next = S_FETCH;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_init = (r_state == S_INIT);
        core_step = (r_state == S_WARMUP) || (r_state == S_GEN);
        fifo_read = (r_state == S_FETCH) && !stop && w_fifo_has_data;
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_data       <= '0;
            r_ks         <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_byte_count <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (start) r_byte_count <= '0;
                S_INIT:   r_step_cnt <= '0;
                S_WARMUP: r_step_cnt <= r_step_cnt + 11'd1;
                S_WAIT_DATA: begin
                    if (fifo_read_stb) begin
                        r_data    <= fifo_dout;
                        r_bit_cnt <= '0;
                    end
                end
                // keystream arrives LSB first; the 8th bit goes straight into the XOR
                S_GEN: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_dout       <= r_data ^ {core_ks, r_ks};
                        r_dout_valid <= 1'b1;
                    end else begin
                        r_ks[r_bit_cnt] <= core_ks;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_dout_valid <= 1'b0;
                        r_byte_count <= r_byte_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign byte_count = r_byte_count;

endmodule
